// File: rtl/svc_rv_dbg_boot.sv
// Boot initiator for the debug bridge: HALT, chunked WRITEs of an image from a ROM port, RELEASE.
// Every command waits for a one-byte ACK (0x06); anything else, or a timeout, ends in ERROR.
module svc_rv_dbg_boot #(
    parameter int unsigned IMG_AW      = 12,
    parameter logic [31:0] LOAD_ADDR   = 32'h0000_0000,
    parameter int unsigned CHUNK_WORDS = 64,
    parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IMG_AW:0]   img_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              img_ren,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [31:0]       img_rdata,
    output logic              cmd_valid,
    output logic [7:0]        cmd_data,
    input  logic              cmd_ready,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_data,
    output logic              rsp_ready
);
    localparam logic [7:0] OP_HALT  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_REL   = 8'h03;
    localparam logic [7:0] RSP_ACK  = 8'h06;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HALT_TX, ST_HALT_ACK, ST_HDR_TX, ST_FETCH, ST_DATA_TX,
        ST_WR_ACK, ST_REL_TX, ST_REL_ACK, ST_DONE, ST_ERROR
    } state_e;

    state_e            state_q;
    logic [IMG_AW:0]   words_q, ptr_q;
    logic [31:0]       addr_q, timer_q;
    logic [23:0]       word_q;
    logic [15:0]       chunk_q, wcnt_q;
    logic [2:0]        idx_q;
    logic              busy_q, done_q, error_q, img_ren_q, cmd_valid_q;
    logic [IMG_AW-1:0] img_addr_q;
    logic [7:0]        cmd_data_q;

    logic [31:0]       remain;
    logic [15:0]       chunk_n;
    logic              words_left, timed_out, chunk_last;
    logic [7:0]        hdr_next, data_next;
    logic [IMG_AW:0]   ptr_inc;

    always_comb begin
        remain     = 32'(words_q) - 32'(ptr_q);
        chunk_n    = (remain < CHUNK_WORDS) ? remain[15:0] : 16'(CHUNK_WORDS);
        words_left = (ptr_q != words_q);
        timed_out  = (timer_q == 32'(ACK_TIMEOUT - 1));
        chunk_last = (wcnt_q == chunk_q - 16'd1);
        ptr_inc    = ptr_q + {{IMG_AW{1'b0}}, 1'b1};
        // idx_q names the byte currently on the bus; these select the one after it
        case (idx_q)
            3'd0:    hdr_next = addr_q[7:0];
            3'd1:    hdr_next = addr_q[15:8];
            3'd2:    hdr_next = addr_q[23:16];
            3'd3:    hdr_next = addr_q[31:24];
            3'd4:    hdr_next = chunk_q[7:0];
            3'd5:    hdr_next = chunk_q[15:8];
            default: hdr_next = 8'h00;
        endcase
        case (idx_q)
            3'd0:    data_next = word_q[7:0];
            3'd1:    data_next = word_q[15:8];
            3'd2:    data_next = word_q[23:16];
            default: data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            words_q     <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            timer_q     <= '0;
            word_q      <= '0;
            chunk_q     <= '0;
            wcnt_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            img_ren_q   <= 1'b0;
            img_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
        end else if (start && !busy_q) begin
            state_q     <= ST_HALT_TX;
            words_q     <= img_words;
            ptr_q       <= '0;
            addr_q      <= LOAD_ADDR;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= OP_HALT;
        end else begin
            case (state_q)
                ST_HALT_TX, ST_REL_TX: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= (state_q == ST_HALT_TX) ? ST_HALT_ACK : ST_REL_ACK;
                    end
                end
                ST_HALT_ACK, ST_WR_ACK, ST_REL_ACK: begin
                    timer_q <= timer_q + 32'd1;
                    if ((rsp_valid && rsp_data != RSP_ACK) || (!rsp_valid && timed_out)) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (rsp_valid) begin
                        if (state_q == ST_REL_ACK) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (words_left) begin
                            state_q     <= ST_HDR_TX;
                            chunk_q     <= chunk_n;
                            wcnt_q      <= '0;
                            idx_q       <= '0;
                            cmd_valid_q <= 1'b1;
                            cmd_data_q  <= OP_WRITE;
                        end else begin
                            state_q     <= ST_REL_TX;
                            cmd_valid_q <= 1'b1;
                            cmd_data_q  <= OP_REL;
                        end
                    end
                end
                ST_HDR_TX: begin
                    if (cmd_ready) begin
                        if (idx_q == 3'd6) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= ST_FETCH;
                            img_ren_q   <= 1'b1;
                            img_addr_q  <= ptr_q[IMG_AW-1:0];
                        end else begin
                            cmd_data_q <= hdr_next;
                            idx_q      <= idx_q + 3'd1;
                        end
                    end
                end
                // img_ren is raised on entry, so its level marks the first of the two FETCH cycles
                ST_FETCH: begin
                    if (img_ren_q) begin
                        img_ren_q <= 1'b0;
                    end else begin
                        word_q      <= img_rdata[31:8];
                        cmd_valid_q <= 1'b1;
                        cmd_data_q  <= img_rdata[7:0];
                        idx_q       <= '0;
                        state_q     <= ST_DATA_TX;
                    end
                end
                ST_DATA_TX: begin
                    if (cmd_ready) begin
                        if (idx_q == 3'd3) begin
                            cmd_valid_q <= 1'b0;
                            ptr_q       <= ptr_inc;
                            wcnt_q      <= wcnt_q + 16'd1;
                            if (chunk_last) begin
                                state_q <= ST_WR_ACK;
                                timer_q <= '0;
                                addr_q  <= addr_q + {14'd0, chunk_q, 2'b00};
                            end else begin
                                state_q    <= ST_FETCH;
                                img_ren_q  <= 1'b1;
                                img_addr_q <= ptr_inc[IMG_AW-1:0];
                            end
                        end else begin
                            cmd_data_q <= data_next;
                            idx_q      <= idx_q + 3'd1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: state_q <= ST_IDLE;
                default:           state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign img_ren   = img_ren_q;
    assign img_addr  = img_addr_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign rsp_ready = 1'b1;
endmodule

// File: tb/tb_svc_rv_dbg_boot.sv
// Directed bench for svc_rv_dbg_boot: two instances (64-word and 2-word chunks) share a ROM
// model and a protocol responder; the captured byte stream is compared against hand-built vectors.
module tb_svc_rv_dbg_boot;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, sel;
    logic [AW:0]   img_words;
    logic [31:0]   img_rdata;
    logic          cmd_ready, rsp_valid;
    logic [7:0]    rsp_data;
    logic          start_a, start_b;

    logic          a_busy, a_done, a_error, a_img_ren, a_cmd_valid, a_rsp_ready;
    logic [AW-1:0] a_img_addr;
    logic [7:0]    a_cmd_data;
    logic          b_busy, b_done, b_error, b_img_ren, b_cmd_valid, b_rsp_ready;
    logic [AW-1:0] b_img_addr;
    logic [7:0]    b_cmd_data;

    logic          m_busy, m_done, m_error, m_img_ren, m_cmd_valid, m_rsp_ready;
    logic [AW-1:0] m_img_addr;
    logic [7:0]    m_cmd_data;

    logic [31:0]   rom [0:(1<<AW)-1];

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    svc_rv_dbg_boot #(.IMG_AW(AW), .LOAD_ADDR(32'h0000_0100), .CHUNK_WORDS(64), .ACK_TIMEOUT(50)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .img_words(img_words),
        .busy(a_busy), .done(a_done), .error(a_error),
        .img_ren(a_img_ren), .img_addr(a_img_addr), .img_rdata(img_rdata),
        .cmd_valid(a_cmd_valid), .cmd_data(a_cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(a_rsp_ready));

    svc_rv_dbg_boot #(.IMG_AW(AW), .LOAD_ADDR(32'h0000_0100), .CHUNK_WORDS(2), .ACK_TIMEOUT(50)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .img_words(img_words),
        .busy(b_busy), .done(b_done), .error(b_error),
        .img_ren(b_img_ren), .img_addr(b_img_addr), .img_rdata(img_rdata),
        .cmd_valid(b_cmd_valid), .cmd_data(b_cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(b_rsp_ready));

    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_done      = sel ? b_done      : a_done;
    assign m_error     = sel ? b_error     : a_error;
    assign m_img_ren   = sel ? b_img_ren   : a_img_ren;
    assign m_img_addr  = sel ? b_img_addr  : a_img_addr;
    assign m_cmd_valid = sel ? b_cmd_valid : a_cmd_valid;
    assign m_cmd_data  = sel ? b_cmd_data  : a_cmd_data;
    assign m_rsp_ready = sel ? b_rsp_ready : a_rsp_ready;

    always @(posedge clk) if (m_img_ren) img_rdata <= rom[m_img_addr];

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned cyc, hold_viol, cmd_cnt, p_idx, p_tot, rsp_dly, halt_cyc, err_cyc, rsp_arg;
    int          rsp_mode;
    logic [7:0]  p_op, rsp_byte, prev_data;
    logic [15:0] p_nw;
    bit          err_seen, rsp_pend, rsp_final, prev_stall, start_on_final;
    logic [7:0]  got[$], exp_q[$], exp_one[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_state();
        got.delete();
        hold_viol = 0; cmd_cnt = 0; p_idx = 0; p_tot = 1; p_op = 8'h00; p_nw = 16'h0;
        rsp_pend = 0; rsp_final = 0; rsp_dly = 0; rsp_byte = 8'h00;
        prev_stall = 0; prev_data = 8'h00; err_seen = 0; err_cyc = 0; halt_cyc = 0;
        rsp_valid = 1'b0; rsp_data = 8'h00; cmd_ready = 1'b1; start = 1'b0;
    endtask

    // One clock: sample just after the edge, then drive this cycle's inputs.
    task automatic step();
        logic [7:0] b;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        if (m_error && !err_seen) begin err_seen = 1; err_cyc = cyc; end
        if (prev_stall && (!m_cmd_valid || m_cmd_data != prev_data)) hold_viol++;
        rsp_valid = 1'b0;
        if (rsp_pend) begin
            if (rsp_dly == 0) begin
                rsp_valid = 1'b1; rsp_data = rsp_byte; rsp_pend = 0;
                if (start_on_final && rsp_final) start = 1'b1;
            end else rsp_dly--;
        end
        cmd_ready = 1'($urandom_range(0, 1));
        if (m_cmd_valid && cmd_ready) begin
            b = m_cmd_data;
            got.push_back(b);
            if (p_idx == 0) begin p_op = b; p_tot = (b == 8'h02) ? 7 : 1; end
            if (p_op == 8'h02 && p_idx == 5) p_nw[7:0] = b;
            if (p_op == 8'h02 && p_idx == 6) begin p_nw[15:8] = b; p_tot = 7 + 4 * 32'(p_nw); end
            p_idx++;
            if (p_idx == p_tot) begin
                p_idx = 0;
                cmd_cnt++;
                if (p_op == 8'h01) halt_cyc = cyc;
                rsp_final = (p_op == 8'h03);
                if (!(rsp_mode == 2 && cmd_cnt >= rsp_arg)) begin
                    rsp_pend = 1;
                    rsp_dly  = $urandom_range(0, 2);
                    rsp_byte = (rsp_mode == 1 && cmd_cnt == rsp_arg) ? 8'h15 : 8'h06;
                end
            end
        end
        prev_stall = m_cmd_valid && !cmd_ready;
        prev_data  = m_cmd_data;
    endtask

    task automatic run(input string tag, input logic s, input int unsigned words,
                       input int mode, input int unsigned arg, input bit on_final);
        int unsigned n;
        clear_state();
        sel = s; img_words = (AW+1)'(words); rsp_mode = mode; rsp_arg = arg; start_on_final = on_final;
        start = 1'b1;
        step();
        chk({tag, "_busy_rise"}, 32'(m_busy), 32'd1);
        chk({tag, "_flags_clr"}, {30'd0, m_done, m_error}, 32'd0);
        n = 0;
        while (m_busy && n < 4000) begin step(); n++; end
        chk({tag, "_finished"}, 32'(n < 4000), 32'd1);
        repeat (12) step();
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_hold"}, hold_viol, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(m_busy), 32'd0);
        chk({tag, "_done"},  32'(m_done), 32'd0);
        chk({tag, "_error"}, 32'(m_error), 32'd0);
        chk({tag, "_ren"},   32'(m_img_ren), 32'd0);
        chk({tag, "_raddr"}, 32'(m_img_addr), 32'd0);
        chk({tag, "_cvalid"}, 32'(m_cmd_valid), 32'd0);
        chk({tag, "_cdata"}, 32'(m_cmd_data), 32'd0);
        chk({tag, "_rready"}, 32'(m_rsp_ready), 32'd1);
    endtask

    initial begin
        int unsigned n;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hC0DE_0000 | 32'(i);
        rom[0] = 32'h1122_3344; rom[1] = 32'hAABB_CCDD; rom[2] = 32'h0000_0000;
        rom[3] = 32'hDEAD_BEEF; rom[4] = 32'h0BAD_F00D;
        cyc = 0; sel = 1'b0; img_words = '0; rsp_mode = 0; rsp_arg = 0; start_on_final = 0;
        clear_state();
        rst = 1'b1;
        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        exp_one = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00,
                    8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h03};

        run("img3", 1'b0, 3, 0, 0, 0);
        exp_q = exp_one;
        chk_stream("img3");
        chk("img3_done", 32'(m_done), 32'd1);
        chk("img3_error", 32'(m_error), 32'd0);

        run("chunk2", 1'b1, 5, 0, 0, 0);
        exp_q = '{8'h01,
                  8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
                  8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                  8'h02, 8'h08, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                  8'h02, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
                  8'h0D, 8'hF0, 8'hAD, 8'h0B,
                  8'h03};
        chk_stream("chunk2");
        chk("chunk2_done", 32'(m_done), 32'd1);

        // start pulsed together with the final ACK must be ignored
        run("empty", 1'b0, 0, 0, 0, 1);
        exp_q = '{8'h01, 8'h03};
        chk_stream("empty");
        chk("empty_done", 32'(m_done), 32'd1);
        chk("empty_no_restart", 32'(m_busy), 32'd0);

        run("nak", 1'b0, 3, 1, 2, 0);
        exp_q = exp_one;
        void'(exp_q.pop_back());
        chk_stream("nak");
        chk("nak_error", 32'(m_error), 32'd1);
        chk("nak_done", 32'(m_done), 32'd0);
        chk("nak_busy", 32'(m_busy), 32'd0);

        run("tmo", 1'b0, 3, 2, 1, 0);
        exp_q = '{8'h01};
        chk_stream("tmo");
        chk("tmo_error", 32'(m_error), 32'd1);
        chk("tmo_latency", err_cyc - halt_cyc - 1, 32'd50);

        // reset in the middle of a data word
        clear_state();
        sel = 1'b0; img_words = 7'd3; rsp_mode = 0; start_on_final = 0;
        start = 1'b1;
        step();
        n = 0;
        while (got.size() < 10 && n < 500) begin step(); n++; end
        chk("rst_reached_data", 32'(got.size() >= 10), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        run("after_rst", 1'b0, 3, 0, 0, 0);
        exp_q = exp_one;
        chk_stream("after_rst");
        chk("after_rst_done", 32'(m_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/svc_rv_dbg_boot.md
# svc_rv_dbg_boot

Hardware boot initiator for the RISC-V SoC debug loader. It drives the command side of the debug bridge byte protocol, the same stream the host loader script produces over UART. On `start` it halts the CPU, copies a program image from a synchronous ROM-style read port into SoC memory with chunked WRITE commands, then releases the CPU, checking an ACK after every command. It sits in place of, or muxed with, the debug UART RX/TX pair in front of the SoC's `dbg_urx_*` / `dbg_utx_*` ports, so a board can boot without a host.

## Interface
Parameters:
- `IMG_AW`, 12: image read-port address width in words.
- `LOAD_ADDR`, 32'h0000_0000: byte address of word 0 in the target memory.
- `CHUNK_WORDS`, 64: maximum words per WRITE command. Range 1..65535.
- `ACK_TIMEOUT`, 1_000_000: cycles allowed between entering an ACK-wait state and receiving the response byte.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a boot sequence. Ignored while `busy`.
- `img_words` in `IMG_AW+1`: image length in words. Sampled on an accepted `start`.
- `busy` out 1: a sequence is in progress.
- `done` out 1: sticky success flag. Cleared by the next accepted `start`.
- `error` out 1: sticky failure flag (NAK or timeout). Cleared by the next accepted `start`.
- `img_ren` out 1: image read enable.
- `img_addr` out `IMG_AW`: image word address.
- `img_rdata` in 32: image word. Valid one cycle after `img_ren`.
- `cmd_valid`, `cmd_data[7:0]` out; `cmd_ready` in: command byte stream to the bridge.
- `rsp_valid`, `rsp_data[7:0]` in; `rsp_ready` out: response byte stream from the bridge.

## Operation
Protocol, fixed for this block; all multi-byte fields are little-endian:
- HALT: one byte, 0x01. Holds the CPU stalled and in reset.
- WRITE: 0x02, then addr[31:0] (4 bytes), then nwords[15:0] (2 bytes), then nwords×4 data bytes, each word LS byte first.
- RELEASE: one byte, 0x03.
- Every command draws exactly one response byte: 0x06 ACK or 0x15 NAK.

FSM states: IDLE, HALT_TX, HALT_ACK, HDR_TX, FETCH, DATA_TX, WR_ACK, REL_TX, REL_ACK, DONE, ERROR.
- IDLE → HALT_TX on `start`. This latches `img_words`, clears `done`/`error`, zeroes the word pointer, and sets addr = `LOAD_ADDR`.
- HALT_TX → HALT_ACK after the byte handshake.
- ACK states on an ACK byte:
  - HALT_ACK → HDR_TX if words remain, else REL_TX.
  - WR_ACK → HDR_TX if words remain, else REL_TX.
  - REL_ACK → DONE.
- Any ACK state on a NAK byte, or on timer expiry → ERROR.
- HDR_TX sends 7 bytes. The chunk size is n = min(CHUNK_WORDS, remaining words). Then → FETCH.
- FETCH asserts `img_ren` for one cycle at the word pointer and captures `img_rdata` the next cycle. Then → DATA_TX.
- DATA_TX sends 4 bytes, then increments the pointer:
  - → FETCH if the chunk is not finished.
  - → WR_ACK when it is; the chunk address advances by 4n.
- DONE and ERROR: `done` or `error` is set, `busy` drops, and the FSM returns to IDLE the next cycle. The flags stay sticky.

Rules:
- `img_words` = 0: HALT then RELEASE, with no WRITE issued.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- `rsp_ready` is held at 1. Response bytes that arrive outside an ACK state are discarded. Bytes other than 0x06/0x15 inside an ACK state are treated as NAK.
- Once ERROR is reached, no further commands are sent; the CPU stays halted.

## Timing
- Reset values: `busy` = `done` = `error` = `img_ren` = `cmd_valid` = 0, `img_addr` = 0, `cmd_data` = 0, `rsp_ready` = 1. Reset takes effect asynchronously and may occur mid-sequence. Any byte in flight is abandoned.
- `cmd_valid` and `cmd_data` are registered. Once asserted they hold stable until `cmd_ready` is seen high. The next byte may be presented in the cycle after a handshake.
- Throughput: with `cmd_ready` held high, a 4-byte data word costs 6 cycles (FETCH 2 + 4 bytes).
- `busy` rises the cycle after `start`. It falls in the same cycle that `done` or `error` rises.
- The timeout counter reloads on entry to each ACK state. ERROR is entered on the cycle the count reaches `ACK_TIMEOUT`.
- A `start` that arrives in the same cycle `done` is set is ignored, because `busy` is still high.

## Test plan
- Image of 3 words (0x11223344, 0xAABBCCDD, 0, …), `LOAD_ADDR` = 0x100, responder ACKs everything. Required command stream: 01 | 02 00 01 00 00 03 00 44 33 22 11 DD CC BB AA … | 03. Then `done` = 1 and `error` = 0.
- `CHUNK_WORDS` = 2, `img_words` = 5 → three WRITEs with nwords 2, 2, 1 and addrs 0x100, 0x108, 0x110.
- `img_words` = 0 → stream 01, 03 only; `done` = 1.
- NAK (0x15) after the first WRITE → `error` = 1, no RELEASE sent, `busy` = 0.
- Responder silent after HALT, `ACK_TIMEOUT` = 50 → `error` rises 50 cycles after HALT_ACK entry. Random `cmd_ready` backpressure on all tests must leave byte order and data unchanged.
- `rst` pulsed during DATA_TX → all outputs at reset values immediately. A new `start` then produces a clean sequence beginning with 0x01.
